// File: rtl/dly_pkg.sv
// Shared encodings and timing constants for the fine delay-locked path.
package dly_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_SETTLE = 2'd2
  } st_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  // Per-cell delay of the fine chain, shared with the delay cell models.
  localparam int T_DLY_FINE_PS = 12;
  localparam int T_DLY_FINE_SPAN_PS = 16 * T_DLY_FINE_PS;

endpackage

// File: rtl/u_dly_therm.sv
// Registered binary-to-thermometer encoder: o_sel[k] = (k < i_code), one cycle latency.
// No backpressure; a new code is accepted every cycle.
module u_dly_therm
  import dly_pkg::*;
#(
  parameter int N_CELL    = 16,
  parameter int CODE_W    = 5,
  parameter int INIT_CODE = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [CODE_W-1:0] i_code,
  output logic [N_CELL-1:0] o_sel
);

  function automatic logic [N_CELL-1:0] therm(input int c);
    logic [N_CELL-1:0] t;
    t = '0;
    for (int k = 0; k < N_CELL; k++) begin
      t[k] = (k < c);
    end
    return t;
  endfunction

  localparam logic [N_CELL-1:0] SEL_INIT = therm(INIT_CODE);

  logic [N_CELL-1:0] sel_d;

  always_comb begin
    sel_d = therm(int'(i_code));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sel <= SEL_INIT;
    end else begin
      o_sel <= sel_d;
    end
  end

endmodule

// File: rtl/u_dly_fine_ctrl.sv
// Fine delay loop controller: filters PD up/down, steps the code by +/-1 with a settle window, tracks lock.
// Outputs registered, updated on the edge consuming the deciding sample; no backpressure, samples ignored while settling.
module u_dly_fine_ctrl
  import dly_pkg::*;
#(
  parameter int N_CELL    = 16,
  parameter int CODE_W    = 5,
  parameter int INIT_CODE = 8,
  parameter int FILT_TH   = 4,
  parameter int SETTLE    = 4,
  parameter int LOCK_CNT  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_pd_vld,
  input  logic              i_up,
  input  logic              i_dn,
  input  logic              i_code_ld,
  input  logic [CODE_W-1:0] i_code,
  output logic [CODE_W-1:0] o_code,
  output logic [N_CELL-1:0] o_sel,
  output logic              o_lock,
  output logic              o_min,
  output logic              o_max
);

  localparam int ACC_W = $clog2(FILT_TH + 1) + 1;
  localparam int REV_W = $clog2(LOCK_CNT + 1);
  localparam int SET_W = $clog2(SETTLE + 1);

  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_TOP = ACC_W'(FILT_TH);
  localparam logic signed [ACC_W-1:0] ACC_BOT = -ACC_TOP;
  localparam logic [REV_W-1:0]  REV_MAX   = REV_W'(LOCK_CNT);
  localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE - 1);
  localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(N_CELL);
  localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(INIT_CODE);

  st_e                      state_q, state_d;
  dir_e                     dir_q, dir_d, step_dir;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_nx;
  logic [SET_W-1:0]         cnt_q, cnt_d;
  logic [REV_W-1:0]         rev_q, rev_d;
  logic                     lock_q, lock_d;
  logic [CODE_W-1:0]        code_q, code_d, code_clamp;
  logic                     min_q, max_q;
  logic                     step_up;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rev_d      = rev_q;
    lock_d     = lock_q;
    code_d     = code_q;
    acc_nx     = acc_q;
    step_up    = 1'b0;
    step_dir   = DIR_NONE;
    code_clamp = (i_code > CODE_MAX) ? CODE_MAX : i_code;

    if (i_code_ld) begin
      code_d  = code_clamp;
      acc_d   = '0;
      rev_d   = '0;
      lock_d  = 1'b0;
      dir_d   = DIR_NONE;
      cnt_d   = SET_LOAD;
      state_d = i_en ? ST_SETTLE : ST_IDLE;
    end else if (!i_en) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      rev_d   = '0;
      lock_d  = 1'b0;
      dir_d   = DIR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          acc_d   = '0;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (i_pd_vld && (i_up ^ i_dn)) begin
            acc_nx = i_up ? acc_q + ACC_ONE : acc_q - ACC_ONE;
            if (acc_nx == ACC_TOP || acc_nx == ACC_BOT) begin
              step_up  = (acc_nx == ACC_TOP);
              step_dir = step_up ? DIR_UP : DIR_DN;
              acc_d    = '0;
              // A step blocked at either rail is dropped without touching history.
              if (!(step_up ? (code_q == CODE_MAX) : (code_q == '0))) begin
                code_d  = step_up ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
                cnt_d   = SET_LOAD;
                state_d = ST_SETTLE;
                if (dir_q == step_dir) begin
                  rev_d  = '0;
                  lock_d = 1'b0;
                end else if (dir_q != DIR_NONE) begin
                  if (rev_q != REV_MAX) rev_d = rev_q + REV_W'(1);
                  if (rev_d == REV_MAX) lock_d = 1'b1;
                end
                dir_d = step_dir;
              end
            end else begin
              acc_d = acc_nx;
            end
          end
        end
        ST_SETTLE: begin
          acc_d = '0;
          if (cnt_q == '0) state_d = ST_TRACK;
          else             cnt_d   = cnt_q - SET_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rev_q   <= '0;
      lock_q  <= 1'b0;
      code_q  <= CODE_INIT;
      min_q   <= (INIT_CODE == 0);
      max_q   <= (INIT_CODE == N_CELL);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rev_q   <= rev_d;
      lock_q  <= lock_d;
      code_q  <= code_d;
      min_q   <= (code_d == '0);
      max_q   <= (code_d == CODE_MAX);
    end
  end

  // Fed from the next-code value so o_sel lands on the same edge as o_code.
  u_dly_therm #(
    .N_CELL   (N_CELL),
    .CODE_W   (CODE_W),
    .INIT_CODE(INIT_CODE)
  ) u_therm (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_code(code_d),
    .o_sel (o_sel)
  );

  assign o_code = code_q;
  assign o_lock = lock_q;
  assign o_min  = min_q;
  assign o_max  = max_q;

endmodule

// File: tb/tb_u_dly_fine_ctrl.sv
// Bench for u_dly_fine_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_u_dly_fine_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_en = 1'b0, i_pd_vld = 1'b0, i_up = 1'b0, i_dn = 1'b0, i_code_ld = 1'b0;
  logic [4:0]  i_code = '0;
  logic [4:0]  o_code;
  logic [15:0] o_sel;
  logic        o_lock, o_min, o_max;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int m_code, m_acc, m_settle_left, m_rev, m_last;
  bit m_active, m_lock;

  always #5 i_clk = ~i_clk;

  u_dly_fine_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_pd_vld(i_pd_vld), .i_up(i_up), .i_dn(i_dn),
    .i_code_ld(i_code_ld), .i_code(i_code), .o_code(o_code), .o_sel(o_sel), .o_lock(o_lock),
    .o_min(o_min), .o_max(o_max)
  );

  function automatic logic [15:0] therm(input int c);
    logic [31:0] t;
    t = (32'd1 << c) - 32'd1;
    return t[15:0];
  endfunction

  task automatic model_reset();
    m_code = 8; m_acc = 0; m_settle_left = 0; m_rev = 0; m_last = 0;
    m_active = 0; m_lock = 0;
  endtask

  task automatic model_step(input bit en, vld, up, dn, ld, input int code);
    int d;
    if (ld) begin
      m_code = (code > 16) ? 16 : code;
      m_acc = 0; m_rev = 0; m_lock = 0; m_last = 0;
      m_active = en;
      m_settle_left = en ? 4 : 0;
    end else if (!en) begin
      m_active = 0; m_settle_left = 0; m_acc = 0; m_rev = 0; m_lock = 0; m_last = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (m_settle_left > 0) begin
      m_settle_left--;
    end else if (vld && (up != dn)) begin
      m_acc += up ? 1 : -1;
      if (m_acc == 4 || m_acc == -4) begin
        d = (m_acc > 0) ? 1 : -1;
        m_acc = 0;
        if (!((d > 0 && m_code == 16) || (d < 0 && m_code == 0))) begin
          m_code += d;
          m_settle_left = 4;
          if (m_last == -d) begin
            m_rev = (m_rev < 8) ? m_rev + 1 : 8;
            if (m_rev == 8) m_lock = 1;
          end else if (m_last == d) begin
            m_rev = 0; m_lock = 0;
          end
          m_last = d;
        end
      end
    end
  endtask

  task automatic drive(input bit en, vld, up, dn, ld, input int code);
    i_en = en; i_pd_vld = vld; i_up = up; i_dn = dn; i_code_ld = ld; i_code = 5'(code);
    model_step(en, vld, up, dn, ld, code);
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_en = 0; i_pd_vld = 0; i_up = 0; i_dn = 0; i_code_ld = 0; i_code = '0;
    i_rst = 1;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 0;
  endtask

  task automatic burst(input bit up_dir);
    repeat (4) drive(1, 1, up_dir, !up_dir, 0, 0);
  endtask

  task automatic settle_wait();
    repeat (4) drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #3 i_rst = 1;
    model_reset();
    #1;
    n_checks++; if (o_code !== 5'd8) begin n_fail++; $display("FAIL reset_code got %0d want 8", o_code); end
    n_checks++; if (o_sel !== 16'h00FF) begin n_fail++; $display("FAIL reset_sel got %h want 00ff", o_sel); end
    n_checks++; if (o_lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock got %b want 0", o_lock); end
    n_checks++; if (o_min !== 1'b0 || o_max !== 1'b0) begin n_fail++; $display("FAIL reset_minmax got %b%b want 00", o_min, o_max); end
    @(posedge i_clk); #1;
    i_rst = 0;
  endtask

  task automatic test_step_up();
    apply_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 1, 0, 0, 0);
      n_checks++;
      if (o_code !== ((i == 4) ? 5'd9 : 5'd8)) begin n_fail++; $display("FAIL step_up sample%0d code got %0d want %0d", i, o_code, (i == 4) ? 9 : 8); end
    end
    n_checks++; if (o_sel !== 16'h01FF) begin n_fail++; $display("FAIL step_up_sel got %h want 01ff", o_sel); end
    repeat (4) drive(1, 1, 1, 0, 0, 0);
    repeat (3) drive(1, 1, 1, 0, 0, 0);
    n_checks++; if (o_code !== 5'd9) begin n_fail++; $display("FAIL settle_ignore code got %0d want 9", o_code); end
    drive(1, 1, 1, 0, 0, 0);
    n_checks++; if (o_code !== 5'd10) begin n_fail++; $display("FAIL second_step code got %0d want 10", o_code); end
  endtask

  task automatic test_filter_cancel();
    apply_reset();
    drive(1, 0, 0, 0, 0, 0);
    repeat (10) begin
      drive(1, 1, 1, 0, 0, 0);
      drive(1, 1, 0, 1, 0, 0);
      drive(1, 1, 1, 0, 0, 0);
      drive(1, 1, 0, 1, 0, 0);
      drive(1, 1, 1, 1, 0, 0);
    end
    n_checks++; if (o_code !== 5'd8) begin n_fail++; $display("FAIL filter_cancel code got %0d want 8", o_code); end
    repeat (3) drive(1, 1, 1, 0, 0, 0);
    repeat (7) drive(1, 1, 0, 1, 0, 0);
    n_checks++; if (o_code !== 5'd7) begin n_fail++; $display("FAIL filter_net code got %0d want 7", o_code); end
    n_checks++; if (o_sel !== 16'h007F) begin n_fail++; $display("FAIL filter_net_sel got %h want 007f", o_sel); end
  endtask

  task automatic test_saturation();
    apply_reset();
    drive(1, 0, 0, 1, 1, 20);
    n_checks++; if (o_code !== 5'd16) begin n_fail++; $display("FAIL sat_ld code got %0d want 16", o_code); end
    n_checks++; if (o_max !== 1'b1 || o_sel !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ld max/sel got %b/%h want 1/ffff", o_max, o_sel); end
    settle_wait();
    repeat (8) drive(1, 1, 1, 0, 0, 0);
    n_checks++; if (o_code !== 5'd16 || o_max !== 1'b1) begin n_fail++; $display("FAIL sat_hi code/max got %0d/%b want 16/1", o_code, o_max); end
    drive(1, 0, 0, 0, 1, 0);
    settle_wait();
    repeat (8) drive(1, 1, 0, 1, 0, 0);
    n_checks++; if (o_code !== 5'd0 || o_min !== 1'b1) begin n_fail++; $display("FAIL sat_lo code/min got %0d/%b want 0/1", o_code, o_min); end
    n_checks++; if (o_sel !== 16'h0000) begin n_fail++; $display("FAIL sat_lo_sel got %h want 0000", o_sel); end
    // one step up after the floor proves the blocked requests left acc clean
    repeat (4) drive(1, 1, 1, 0, 0, 0);
    n_checks++; if (o_code !== 5'd1 || o_min !== 1'b0) begin n_fail++; $display("FAIL sat_release code/min got %0d/%b want 1/0", o_code, o_min); end
  endtask

  task automatic test_lock();
    apply_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int b = 0; b < 9; b++) begin
      burst(b % 2 == 0);
      n_checks++;
      if (o_lock !== (b >= 8)) begin n_fail++; $display("FAIL lock_burst%0d got %b want %b", b, o_lock, b >= 8); end
      settle_wait();
    end
    burst(1);
    n_checks++; if (o_lock !== 1'b0) begin n_fail++; $display("FAIL lock_clear got %b want 0", o_lock); end
    n_checks++; if (o_code !== 5'd10) begin n_fail++; $display("FAIL lock_code got %0d want 10", o_code); end
  endtask

  task automatic test_disable_reset();
    apply_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int b = 0; b < 9; b++) begin
      burst(b % 2 == 0);
      if (b < 8) settle_wait();
    end
    n_checks++; if (o_lock !== 1'b1) begin n_fail++; $display("FAIL dis_prelock got %b want 1", o_lock); end
    drive(0, 1, 1, 0, 0, 0);
    n_checks++; if (o_code !== 5'd9 || o_lock !== 1'b0) begin n_fail++; $display("FAIL dis_settle code/lock got %0d/%b want 9/0", o_code, o_lock); end
    drive(1, 0, 0, 0, 0, 0);
    burst(1);
    n_checks++; if (o_code !== 5'd10) begin n_fail++; $display("FAIL dis_resume code got %0d want 10", o_code); end
    drive(1, 1, 1, 0, 0, 0);
    #2 i_rst = 1;
    model_reset();
    #1;
    n_checks++; if (o_code !== 5'd8 || o_sel !== 16'h00FF || o_lock !== 1'b0) begin n_fail++; $display("FAIL rst_settle code/sel/lock got %0d/%h/%b want 8/00ff/0", o_code, o_sel, o_lock); end
    @(posedge i_clk); #1;
    i_rst = 0;
  endtask

  task automatic test_ld_vs_step();
    apply_reset();
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 1, 3);
    n_checks++; if (o_code !== 5'd3 || o_sel !== 16'h0007) begin n_fail++; $display("FAIL ld_vs_step code/sel got %0d/%h want 3/0007", o_code, o_sel); end
    repeat (4) drive(1, 1, 1, 0, 0, 0);
    n_checks++; if (o_code !== 5'd3) begin n_fail++; $display("FAIL ld_settle code got %0d want 3", o_code); end
    repeat (4) drive(1, 1, 1, 0, 0, 0);
    n_checks++; if (o_code !== 5'd4) begin n_fail++; $display("FAIL ld_after code got %0d want 4", o_code); end
    drive(0, 0, 0, 0, 1, 12);
    n_checks++; if (o_code !== 5'd12) begin n_fail++; $display("FAIL ld_disabled code got %0d want 12", o_code); end
  endtask

  task automatic test_random();
    bit bias, en, vld, up, dn, ld;
    int r, code;
    apply_reset();
    bias = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bias = !bias;
      en  = ($urandom_range(0, 49) != 0);
      vld = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 7);
      if (r < 5)       begin up = bias;  dn = !bias; end
      else if (r == 5) begin up = 1;     dn = 1;     end
      else if (r == 6) begin up = !bias; dn = bias;  end
      else             begin up = 0;     dn = 0;     end
      ld   = ($urandom_range(0, 79) == 0);
      code = $urandom_range(0, 31);
      drive(en, vld, up, dn, ld, code);
      n_checks++;
      if (o_code !== 5'(m_code) || o_sel !== therm(m_code) || o_lock !== m_lock ||
          o_min !== (m_code == 0) || o_max !== (m_code == 16)) begin
        n_fail++;
        $display("FAIL random cyc%0d code/sel/lock/min/max got %0d/%h/%b/%b/%b want %0d/%h/%b/%b/%b",
                 i, o_code, o_sel, o_lock, o_min, o_max, m_code, therm(m_code), m_lock, m_code == 0, m_code == 16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_step_up();
    test_filter_cancel();
    test_saturation();
    test_lock();
    test_disable_reset();
    test_ld_vs_step();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
